datapath_core: RTL

Parametrised successor to the fixed 16×16 register-file/ALU datapath. It combines a register file of `P_REGS` × `P_N` bits, two read selects, an ALU and an iterative unsigned divider behind a valid/ready command port. The block replaces the hard-wired control word with an accepted command, and exposes one register as a live output. It sits between a sequencer (control unit) and the board-level outputs.

---
 rtl/datapath_core.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/datapath_core.sv
// rtl/datapath_core.sv - register file, ALU and restoring divider behind a valid/ready command port
module datapath_core #(
    parameter int P_N       = 16,
    parameter int P_REGS    = 16,
    parameter int P_OUT_REG = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [2:0]                  cmd_op,
    input  logic [$clog2(P_REGS)-1:0]   cmd_sel_a,
    input  logic [$clog2(P_REGS)-1:0]   cmd_sel_b,
    input  logic [$clog2(P_REGS)-1:0]   cmd_sel_w,
    input  logic                        cmd_we,
    input  logic [P_N-1:0]              cmd_imm,
    output logic [P_N-1:0]              o_result,
    output logic                        o_mayor,
    output logic                        o_paridad,
    output logic                        o_zero,
    output logic                        o_done,
    output logic [P_N-1:0]              o_out
);
    localparam int P_SEL = $clog2(P_REGS);
    localparam int P_CW  = $clog2(P_N);
    localparam logic [P_SEL-1:0] OUT_IDX = P_SEL'(P_OUT_REG);

    typedef enum logic [2:0] {IDLE, EXEC, DIV_RUN, DIV_WBQ, DIV_WBR} state_t;

    state_t             state;
    logic [P_N-1:0]     rf [P_REGS];
    logic [P_N-1:0]     a_q, b_q, imm_q, quo_q, rem_q;
    logic [2:0]         op_q;
    logic [P_SEL-1:0]   w_q, w_next;
    logic               we_q;
    logic [P_CW-1:0]    cnt_q;

    logic [P_N-1:0]     rd_a, rd_b, alu_res, rem_next;
    logic [P_N:0]       trial, diff;
    logic               trial_ge;

    assign rd_a      = rf[cmd_sel_a];
    assign rd_b      = rf[cmd_sel_b];
    assign o_out     = rf[OUT_IDX];
    assign cmd_ready = (state == IDLE);
    assign w_next    = w_q + 1'b1;

    always_comb begin
        alu_res = '0;
        case (op_q)
            3'b000:  alu_res = a_q + b_q;
            3'b001:  alu_res = a_q - b_q;
            3'b010:  alu_res = a_q & b_q;
            3'b011:  alu_res = a_q | b_q;
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = {1'b0, a_q[P_N-1:1]};
            3'b110:  alu_res = imm_q;
            default: alu_res = '0;
        endcase
    end

    // quo_q shifts dividend bits out at the top while quotient bits enter at the bottom
    always_comb begin
        trial    = {rem_q, quo_q[P_N-1]};
        diff     = trial - {1'b0, b_q};
        trial_ge = (trial >= {1'b0, b_q});
        rem_next = trial_ge ? diff[P_N-1:0] : trial[P_N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < P_REGS; i++) rf[i] <= '0;
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            imm_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            op_q      <= '0;
            w_q       <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            o_result  <= '0;
            o_mayor   <= 1'b0;
            o_paridad <= 1'b0;
            o_zero    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q   <= rd_a;
                        b_q   <= rd_b;
                        imm_q <= cmd_imm;
                        op_q  <= cmd_op;
                        w_q   <= cmd_sel_w;
                        we_q  <= cmd_we;
                        if (cmd_op == 3'b111) begin
                            if (rd_b == '0) begin
                                quo_q <= '1;
                                rem_q <= rd_a;
                                state <= DIV_WBQ;
                            end else begin
                                quo_q <= rd_a;
                                rem_q <= '0;
                                cnt_q <= P_CW'(P_N - 1);
                                state <= DIV_RUN;
                            end
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (we_q) rf[w_q] <= alu_res;
                    o_result  <= alu_res;
                    o_mayor   <= (a_q > b_q);
                    o_zero    <= (alu_res == '0);
                    o_paridad <= ^alu_res;
                    o_done    <= 1'b1;
                    state     <= IDLE;
                end
                DIV_RUN: begin
                    quo_q <= {quo_q[P_N-2:0], trial_ge};
                    rem_q <= rem_next;
                    if (cnt_q == '0) state <= DIV_WBQ;
                    else             cnt_q <= cnt_q - 1'b1;
                end
                DIV_WBQ: begin
                    if (we_q) rf[w_q] <= quo_q;
                    o_result  <= quo_q;
                    o_mayor   <= (a_q > b_q);
                    o_zero    <= (quo_q == '0);
                    o_paridad <= ^quo_q;
                    state     <= DIV_WBR;
                end
                DIV_WBR: begin
                    if (we_q) rf[w_next] <= rem_q;
                    o_done <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
